// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction ROM port, redirect input and issue-side queue head.
// The fetch unit sits on the master side.
interface fetch_if #(
  parameter int DEPTH = 4
) ();
  logic                     rom_nrd;
  logic [31:0]              rom_addr;
  logic [31:0]              rom_data;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     inst_valid;
  logic                     inst_ready;
  logic [31:0]              inst_out;
  logic [31:0]              inst_pc;
  logic [$clog2(DEPTH):0]   count;
  logic                     halted;

  modport master (
    output rom_nrd, rom_addr, inst_valid, inst_out, inst_pc, count, halted,
    input  rom_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  rom_nrd, rom_addr, inst_valid, inst_out, inst_pc, count, halted,
    output rom_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, DEPTH-entry {instr, pc} queue, and a halt flag
// raised by the halt opcode or by running off the end of the ROM.
module fetch_unit #(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ROM_BYTES   = 100,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic      clk,
  input logic      nrst,
  fetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          halted;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic pop;
  logic fetch_en;
  logic end_of_rom;
  logic halt_word;

  assign pop        = (count != '0) && bus.inst_ready;
  // 33-bit compare so a PC near 2^32 cannot wrap past the ROM limit
  assign end_of_rom = ({1'b0, pc} + 33'd3) >= 33'(ROM_BYTES);
  assign fetch_en   = nrst && !halted && !bus.redirect && !end_of_rom &&
                      ((count < CW'(DEPTH)) || pop);
  assign halt_word  = (bus.rom_data[31:26] == HALT_OPCODE);

  assign bus.rom_nrd    = !fetch_en;
  assign bus.rom_addr   = pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_out   = q_instr[rd_ptr];
  assign bus.inst_pc    = q_pc[rd_ptr];
  assign bus.count      = count;
  assign bus.halted     = halted;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (fetch_en) begin
      q_instr[wr_ptr] <= bus.rom_data;
      q_pc[wr_ptr]    <= pc;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else if (bus.redirect) begin
      // redirect wins over any push or pop presented in the same cycle
      pc     <= bus.redirect_pc & ~32'd3;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      if (fetch_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc     <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({fetch_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if ((fetch_en && halt_word) || end_of_rom) begin
        halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_BYTES = 100;
  localparam logic [5:0]  HALT      = 6'b111111;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] rom [0:31];
  logic [31:0] last_pc;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done;

  fetch_if #(.DEPTH(DEPTH)) bus ();

  fetch_unit #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .ROM_BYTES(ROM_BYTES), .HALT_OPCODE(HALT)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd128) return rom[a[6:2]];
    return 32'h0BAD_0BAD;
  endfunction

  function automatic logic [31:0] rnd_word(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (allow_halt && ($urandom_range(15) == 0)) w[31:26] = HALT;
    else if (w[31:26] == HALT) w[26] = 1'b0;
    return w;
  endfunction

  task automatic fill_rom(input bit allow_halt);
    for (int i = 0; i < 32; i++) rom[i] = rnd_word(allow_halt);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_halted = 1'b0;
  endtask

  // One clock cycle: optional reset pulse, drive inputs, check outputs, advance model.
  task automatic step(input bit ready, input bit redir, input logic [31:0] rpc, input bit do_rst);
    bit   pop, eor, exp_fetch;
    ent_t e;
    @(negedge clk);
    if (do_rst) begin
      nrst = 1'b0;
      #1;
      chk_eq("rst_pulse_count", 32'(bus.count), 32'd0);
      chk_eq("rst_pulse_valid", 32'(bus.inst_valid), 32'd0);
      chk_eq("rst_pulse_nrd", 32'(bus.rom_nrd), 32'd1);
      model_reset();
      #2;
    end
    nrst = 1'b1;
    bus.inst_ready  = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.rom_data    = rom_word(bus.rom_addr);
    #1;
    pop       = (mq.size() != 0) && ready;
    eor       = ({1'b0, m_pc} + 33'd3) >= 33'(ROM_BYTES);
    exp_fetch = !m_halted && !redir && !eor && ((mq.size() < DEPTH) || pop);

    chk_eq("count", 32'(bus.count), 32'(mq.size()));
    chk_eq("inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
    chk_eq("halted", 32'(bus.halted), 32'(m_halted));
    chk_eq("rom_nrd", 32'(bus.rom_nrd), 32'(!exp_fetch));
    chk_eq("rom_addr", bus.rom_addr, m_pc);
    if (mq.size() != 0) begin
      chk_eq("inst_out", bus.inst_out, mq[0].ins);
      chk_eq("inst_pc", bus.inst_pc, mq[0].pc);
    end
    if (bus.rom_nrd == 1'b0)
      chk_eq("read_inside_rom", 32'(({1'b0, bus.rom_addr} + 33'd3) < 33'(ROM_BYTES)), 32'd1);
    if (bus.inst_valid && ready && !redir) last_pc = bus.inst_pc;

    if (redir) begin
      mq.delete();
      m_pc = rpc & ~32'd3;
      m_halted = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (exp_fetch) begin
        e.ins = rom_word(m_pc);
        e.pc  = m_pc;
        mq.push_back(e);
        if (e.ins[31:26] == HALT) m_halted = 1'b1;
        m_pc = m_pc + 32'd4;
      end
      if (eor) m_halted = 1'b1;
    end
  endtask

  initial begin
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.rom_data    = '0;
    last_pc         = '0;
    fill_rom(1'b0);
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk_eq("reset_count", 32'(bus.count), 32'd0);
    chk_eq("reset_valid", 32'(bus.inst_valid), 32'd0);
    chk_eq("reset_nrd", 32'(bus.rom_nrd), 32'd1);
    chk_eq("reset_addr", bus.rom_addr, RESET_PC);
    chk_eq("reset_inst_out", bus.inst_out, 32'd0);
    chk_eq("reset_inst_pc", bus.inst_pc, 32'd0);
    chk_eq("reset_halted", 32'(bus.halted), 32'd0);

    // stall from reset: queue fills to DEPTH and the PC parks at 16
    repeat (6) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk_eq("stall_count", 32'(bus.count), 32'd4);
    chk_eq("stall_nrd", 32'(bus.rom_nrd), 32'd1);
    chk_eq("stall_addr", bus.rom_addr, 32'd16);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk_eq("full_push_pop_count", 32'(bus.count), 32'd4);

    // reset pulse, build three entries, then redirect to a misaligned target
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0022, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk_eq("redir_count", 32'(bus.count), 32'd0);
    chk_eq("redir_addr", bus.rom_addr, 32'h20);
    chk_eq("redir_halted", 32'(bus.halted), 32'd0);
    chk_eq("redir_fetch", 32'(bus.rom_nrd), 32'd0);

    // run off the end of the ROM
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      done = bus.halted && (bus.count == '0);
    end
    chk_eq("eor_drained", 32'(done), 32'd1);
    chk_eq("eor_last_pc", last_pc, 32'd96);

    // halt opcode at address 8 after a reset pulse
    rom[2] = 32'hFC00_0000;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      done = bus.halted && (bus.count == '0);
    end
    chk_eq("halt_drained", 32'(done), 32'd1);
    chk_eq("halt_last_pc", last_pc, 32'd8);
    chk_eq("halt_nrd", 32'(bus.rom_nrd), 32'd1);

    // random traffic with halt words, redirects and reset pulses
    fill_rom(1'b1);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(19) == 0),
           32'($urandom_range(127)), ($urandom_range(96) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: fetch queue entries, power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC after reset.
REQ-003 Parameter ROM_BYTES, default 100: byte size of instruction memory.
REQ-004 Parameter HALT_OPCODE, default 6'b111111: opcode (bits 31:26) that stops fetching.
REQ-005 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-006 Port nrst  in  1: asynchronous, active-low reset.
REQ-007 Port rom_nrd  out  1: memory read strobe, active low.
REQ-008 Port rom_addr  out  32: byte address of the word requested.
REQ-009 Port rom_data  in  32: big-endian word, valid combinationally in the same cycle as rom_nrd=0.
REQ-010 Port redirect  in  1: branch or jump redirect strobe.
REQ-011 Port redirect_pc  in  32: new fetch address, sampled when redirect=1.
REQ-012 Port inst_valid  out  1: queue head holds a valid instruction.
REQ-013 Port inst_ready  in  1: issue stage accepts the head this cycle.
REQ-014 Port inst_out  out  32: instruction at the queue head.
REQ-015 Port inst_pc  out  32: PC of the queue-head instruction.
REQ-016 Port count  out  $clog2(DEPTH)+1: number of occupied entries.
REQ-017 Port halted  out  1: fetching stopped on HALT_OPCODE or end of ROM.

Function
REQ-018 The block SHALL keep a fetch PC register, a circular queue of DEPTH {instr, pc} entries, read and write pointers, and a halted flag.
REQ-019 fetch_en SHALL be (nrst=1) && !halted && !redirect && (count<DEPTH || pop); pop = inst_valid && inst_ready.
REQ-020 rom_nrd SHALL be 0 exactly when fetch_en=1; rom_addr SHALL equal PC in every cycle.
REQ-021 On a rising edge with fetch_en=1, the block SHALL push {rom_data, PC} and set PC to PC+4, modulo 2^32.
REQ-022 Fetch latency: a word requested in cycle N SHALL be visible at the head in cycle N+1 at the earliest.
REQ-023 inst_valid SHALL equal (count!=0); inst_out and inst_pc SHALL come directly from the head entry registers, with no combinational path from rom_data.
REQ-024 A pop SHALL advance the read pointer by 1; the pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; this is allowed when count=DEPTH.
REQ-026 No push SHALL occur when count=DEPTH and there is no pop; PC SHALL hold.
REQ-027 A pushed word with bits[31:26]=HALT_OPCODE SHALL set halted=1 at that edge; the halt word itself SHALL be enqueued; PC SHALL advance normally.
REQ-028 If PC+3 >= ROM_BYTES, fetch_en SHALL be 0 and halted SHALL be set at the next edge; no partial word SHALL ever be enqueued.
REQ-029 On redirect=1, at the next edge the block SHALL empty the queue (count=0, pointers=0), set PC=redirect_pc, and clear halted.
REQ-030 Redirect SHALL take priority over push and pop in the same cycle; that cycle's pop SHALL be discarded, and the issue stage SHALL ignore that cycle's handshake.
REQ-031 redirect_pc SHALL be word-aligned; bits[1:0] SHALL be forced to 0.
REQ-032 While halted=1 and there is no redirect, the queue SHALL continue to drain via pops.

Reset
REQ-033 While nrst=0: PC=RESET_PC, count=0, pointers=0, halted=0, inst_valid=0, rom_nrd=1.
REQ-034 inst_out and inst_pc SHALL reset to 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronous), and fetching SHALL restart at RESET_PC on the first edge after release.

Verification
REQ-036 Reset release, inst_ready=1, ROM words A@0,B@4,C@8 -> rom_addr 0,4,8 on consecutive cycles; inst_out A,B,C with inst_pc 0,4,8 one cycle later each.
REQ-037 inst_ready=0 for 6 cycles, DEPTH=4 -> count reaches 4, rom_nrd=1 and rom_addr holds 16; then inst_ready=1 -> push and pop in the same cycle, count stays 4.
REQ-038 Word 32'hFC00_0000 at address 8 -> halted=1 after its push, rom_nrd=1 afterwards; the queue drains to count=0 with the last inst_pc=8.
REQ-039 Queue holding 3 entries, redirect=1 with redirect_pc=32'h0000_0022 -> next cycle count=0, PC=32'h20, halted=0; the following cycle fetches address 32'h20.
REQ-040 ROM_BYTES=100 with no halt word -> last enqueued inst_pc=96, halted=1, and address 100 is never read with rom_nrd=0.
REQ-041 nrst pulsed low for half a cycle with count=2 -> count=0, inst_valid=0 immediately; after release, fetching resumes at RESET_PC.
